// File: rtl/sb_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
// Counter width and register count here are the defaults used by reg_scoreboard.
package sb_pkg;

    localparam int SB_NREG    = 32;
    localparam int SB_CNT_W   = 3;
    localparam int SB_NISSUE  = 2;
    localparam int SB_NRETIRE = 2;
    localparam int SB_NQ      = 4;

    typedef logic [$clog2(SB_NREG)-1:0] reg_idx_t;
    typedef logic [SB_CNT_W-1:0]        sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = {SB_CNT_W{1'b1}};

endpackage

// File: rtl/sb_counter.sv
// Saturation-free outstanding-writer counter for one architectural register.
// The ready logic upstream guarantees inc never pushes the count past its maximum.
module sb_counter #(
    parameter int CNT_W = 3,
    parameter int INC_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [INC_W-1:0] inc_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             underflow_o
);

    localparam int SW = CNT_W + 2;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SW-1:0]    up_s;
    logic [SW-1:0]    dn_s;

    assign up_s = SW'(cnt_q) + SW'(inc_i);
    assign dn_s = SW'(dec_i);

    // Next count: flush wins, otherwise cnt + inc - dec clamped at zero
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (up_s < dn_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(up_s - dn_s);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign zero_o      = (cnt_q == '0);
    assign underflow_o = (dn_s > SW'(cnt_q));

endmodule

// File: rtl/reg_scoreboard.sv
// Multi-port register-hazard scoreboard: per-register writer counters with
// priority-ordered issue acceptance, multi-port retire and source-busy queries.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG    = SB_NREG,
    parameter int CNT_W   = SB_CNT_W,
    parameter int NISSUE  = SB_NISSUE,
    parameter int NRETIRE = SB_NRETIRE,
    parameter int NQ      = SB_NQ,
    parameter bit BYPASS  = 1'b1,
    localparam int RW     = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NISSUE-1:0]       iss_valid,
    input  logic [NISSUE*RW-1:0]    iss_rd,
    output logic [NISSUE-1:0]       iss_ready,
    input  logic [NRETIRE-1:0]      ret_valid,
    input  logic [NRETIRE*RW-1:0]   ret_rd,
    input  logic                    flush,
    input  logic [NQ*RW-1:0]        q_rs,
    output logic [NQ-1:0]           q_busy,
    output logic [NREG-1:0]         busy_vec,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    localparam int IW      = $clog2(NISSUE + 1);
    localparam int DW      = $clog2(NRETIRE + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0]  cnt_s   [NREG];
    logic [IW-1:0]     inc_s   [NREG];
    logic [DW-1:0]     dec_s   [NREG];
    logic [NREG-1:0]   zero_s;
    logic [NREG-1:0]   uflow_s;
    logic [NISSUE-1:0] live_s;
    logic [NISSUE-1:0] ready_s;
    logic [NQ-1:0]     q_busy_s;
    logic              ovf_s;
    logic              err_ovf_q;
    logic              err_ovf_d;
    logic              err_udf_q;
    logic              err_udf_d;

    // A port is live when it requests a real (non-zero) destination
    always_comb begin
        live_s = '0;
        for (int k = 0; k < NISSUE; k++) begin
            if (iss_valid[k] && (iss_rd[k*RW +: RW] != '0)) begin
                live_s[k] = 1'b1;
            end else begin
                live_s[k] = 1'b0;
            end
        end
    end

    // Priority acceptance: older accepted ports to the same rd consume headroom first
    always_comb begin
        ready_s = '0;
        ovf_s   = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc_s[r] = '0;
        end
        for (int k = 0; k < NISSUE; k++) begin
            int same_v;
            same_v = 0;
            for (int j = 0; j < k; j++) begin
                if (live_s[j] && ready_s[j] && (iss_rd[j*RW +: RW] == iss_rd[k*RW +: RW])) begin
                    same_v = same_v + 1;
                end else begin
                    same_v = same_v + 0;
                end
            end
            if (!live_s[k]) begin
                ready_s[k] = 1'b1;
            end else if (int'(cnt_s[iss_rd[k*RW +: RW]]) + same_v + 1 <= CNT_MAX) begin
                ready_s[k] = 1'b1;
                inc_s[iss_rd[k*RW +: RW]] = inc_s[iss_rd[k*RW +: RW]] + IW'(1);
            end else begin
                ready_s[k] = 1'b0;
                ovf_s      = 1'b1;
            end
        end
    end

    // Retire reduction; retires of r0 are ignored
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec_s[r] = '0;
        end
        for (int p = 0; p < NRETIRE; p++) begin
            if (ret_valid[p] && (ret_rd[p*RW +: RW] != '0)) begin
                dec_s[ret_rd[p*RW +: RW]] = dec_s[ret_rd[p*RW +: RW]] + DW'(1);
            end else begin
                dec_s[0] = dec_s[0];
            end
        end
    end

    assign cnt_s[0]   = '0;
    assign zero_s[0]  = 1'b1;
    assign uflow_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W),
            .INC_W (IW),
            .DEC_W (DW)
        ) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .flush_i     (flush),
            .inc_i       (inc_s[r]),
            .dec_i       (dec_s[r]),
            .cnt_o       (cnt_s[r]),
            .zero_o      (zero_s[r]),
            .underflow_o (uflow_s[r])
        );
    end

    // Source queries; with bypass a same-cycle retire draining the count reads as free
    always_comb begin
        q_busy_s = '0;
        for (int i = 0; i < NQ; i++) begin
            if (q_rs[i*RW +: RW] == '0) begin
                q_busy_s[i] = 1'b0;
            end else if (BYPASS) begin
                q_busy_s[i] = int'(cnt_s[q_rs[i*RW +: RW]]) > int'(dec_s[q_rs[i*RW +: RW]]);
            end else begin
                q_busy_s[i] = (cnt_s[q_rs[i*RW +: RW]] != '0);
            end
        end
    end

    assign err_ovf_d = err_ovf_q | ovf_s;
    assign err_udf_d = err_udf_q | (|uflow_s);

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign iss_ready     = ready_s;
    assign q_busy        = q_busy_s;
    assign busy_vec      = ~zero_s;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;

endmodule
